// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_port_arbiter
// Purpose  : Two-port arbiter in front of a single-port data RAM. Port 0
//            (pipeline MEM stage) has priority. Port 1 (loader/debug/DMA) wins
//            once it has been refused STARVE_LIMIT cycles in a row. Grant is
//            combinational, and the RAM is accessed in the grant cycle. Read
//            data returns registered one cycle later.
// Options  : DMEM_ARB_STATS_EN adds conflict/starvation counters and a
//            synchronous clear input for them.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_port_arbiter #(
    parameter int DW           = 32,
    parameter int AW           = 24,
    parameter int DEPTH        = 128,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          clear,
    input  logic          req0,
    input  logic          wr0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          gnt0,
    output logic          rvalid0,
    output logic [DW-1:0] rdata0,
    output logic          stall0,
    input  logic          req1,
    input  logic          wr1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt1,
    output logic          rvalid1,
    output logic [DW-1:0] rdata1,
    output logic          err,
    output logic          ram_wr,
    output logic          ram_rd,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
`ifdef DMEM_ARB_STATS_EN
    ,
    input  logic          stats_clr,
    output logic [15:0]   conflict_cnt,
    output logic [15:0]   starve_cnt
`endif
);

    localparam logic [7:0]  c_STARVE_LIMIT = 8'(STARVE_LIMIT);
    localparam logic [AW:0] c_DEPTH        = (AW+1)'(DEPTH);

    logic [7:0]    wait_cnt_q, wait_cnt_d;
    logic          force1;
    logic          any_gnt;
    logic          sel_wr;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          in_range;
    logic [DW-1:0] rd_data_d;
    logic          rvalid0_q, rvalid1_q, err_q;
    logic [DW-1:0] rdata0_q, rdata1_q;

    // Arbitration: port 0 wins unless port 1 has waited long enough.
    // Grants are held low while clear is asserted.
    always_comb begin
        force1 = req1 & (wait_cnt_q == c_STARVE_LIMIT);
        gnt1   = clear & req1 & (~req0 | force1);
        gnt0   = clear & req0 & ~gnt1;
        stall0 = req0 & ~gnt0;
    end

    // Steer the granted port onto the RAM and qualify enables by address range
    always_comb begin
        sel_wr    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        if (gnt0) begin
            sel_wr    = wr0;
            sel_addr  = addr0;
            sel_wdata = wdata0;
        end else if (gnt1) begin
            sel_wr    = wr1;
            sel_addr  = addr1;
            sel_wdata = wdata1;
        end
        any_gnt   = gnt0 | gnt1;
        in_range  = ({1'b0, sel_addr} < c_DEPTH);
        ram_wr    = any_gnt & sel_wr & in_range;
        ram_rd    = any_gnt & ~sel_wr & in_range;
        ram_addr  = sel_addr;
        ram_wdata = sel_wdata;
        // Out-of-range reads return zero instead of whatever the RAM drives
        rd_data_d = in_range ? ram_rdata : '0;
    end

    // Starvation counter next state: counts refused cycles, saturating
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (gnt1 | ~req1) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q < c_STARVE_LIMIT) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end
    end

    // State registers: wait counter, read-return path and error pulse
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            wait_cnt_q <= '0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            rvalid0_q  <= gnt0 & ~wr0;
            rvalid1_q  <= gnt1 & ~wr1;
            err_q      <= any_gnt & ~in_range;
            if (gnt0 & ~wr0) begin
                rdata0_q <= rd_data_d;
            end
            if (gnt1 & ~wr1) begin
                rdata1_q <= rd_data_d;
            end
        end
    end

    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;
    assign err     = err_q;

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] conflict_cnt_q, starve_cnt_q;

    // Saturating contention/starvation statistics with synchronous clear
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            conflict_cnt_q <= '0;
            starve_cnt_q   <= '0;
        end else if (stats_clr) begin
            conflict_cnt_q <= '0;
            starve_cnt_q   <= '0;
        end else begin
            if (req0 & req1 & (conflict_cnt_q != 16'hFFFF)) begin
                conflict_cnt_q <= conflict_cnt_q + 16'd1;
            end
            if (gnt1 & force1 & (starve_cnt_q != 16'hFFFF)) begin
                starve_cnt_q <= starve_cnt_q + 16'd1;
            end
        end
    end

    assign conflict_cnt = conflict_cnt_q;
    assign starve_cnt   = starve_cnt_q;
`endif

endmodule
`default_nettype wire
